// File: rtl/acc_icb_slave.sv
// ICB responder for the accelerator: CTRL/MODE registers, buffer write/read port, start pulse.
// Define ACC_ICB_RDBACK_EN to let data-window reads fetch from the buffer (latency 2).
module acc_icb_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
   parameter int          BUF_AW    = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icb_cmd_valid,
   output logic              icb_cmd_ready,
   input  logic              icb_cmd_read,
   input  logic [31:0]       icb_cmd_addr,
   input  logic [31:0]       icb_cmd_wdata,
   input  logic [3:0]        icb_cmd_wmask,
   output logic              icb_rsp_valid,
   input  logic              icb_rsp_ready,
   output logic [31:0]       icb_rsp_rdata,
   output logic              icb_rsp_err,
   output logic              start_o,
   output logic [1:0]        mode_o,
   output logic              buf_we,
   output logic              buf_re,
   output logic [BUF_AW-1:0] buf_addr,
   output logic [31:0]       buf_wdata,
   output logic [3:0]        buf_wmask,
   input  logic [31:0]       buf_rdata,
   input  logic              acc_busy,
   input  logic              acc_done
);

`ifdef ACC_ICB_RDBACK_EN
   localparam bit RDBACK = 1'b1;
`else
   localparam bit RDBACK = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT, S_RSP} state_t;

   state_t              state_reg, state_next;
   logic                rsp_valid_reg;
   logic [31:0]         rsp_rdata_reg;
   logic                rsp_err_reg;
   logic                op_we_reg, op_re_reg, op_start_reg;
   logic [BUF_AW-1:0]   buf_addr_reg;
   logic [31:0]         buf_wdata_reg;
   logic [3:0]          buf_wmask_reg;
   logic [1:0]          mode_reg;
   logic                done_sticky_reg;

   logic        cmd_fire, rsp_fire;
   logic [12:0] off, idx_full;
   logic        region_hit, hit_ctrl, hit_mode, hit_win, idx_ok;
   logic        do_bufwr, do_bufrd, do_start, do_w1c, cmd_err;
   logic [31:0] rd_value;

   assign icb_cmd_ready = (state_reg == S_IDLE);
   assign cmd_fire      = icb_cmd_valid & icb_cmd_ready;
   assign icb_rsp_valid = rsp_valid_reg | (state_reg == S_RDWAIT);
   assign rsp_fire      = icb_rsp_valid & icb_rsp_ready;
   // The buffer's output is only valid during RDWAIT; it is captured for any later stall.
   assign icb_rsp_rdata = (state_reg == S_RDWAIT) ? buf_rdata : rsp_rdata_reg;
   assign icb_rsp_err   = rsp_err_reg;

   assign buf_we    = (state_reg == S_ISSUE) & op_we_reg;
   assign buf_re    = (state_reg == S_ISSUE) & op_re_reg;
   assign start_o   = (state_reg == S_ISSUE) & op_start_reg;
   assign buf_addr  = buf_addr_reg;
   assign buf_wdata = buf_wdata_reg;
   assign buf_wmask = buf_wmask_reg;
   assign mode_o    = mode_reg;

   assign off        = icb_cmd_addr[12:0];
   assign idx_full   = off - 13'd8;
   assign region_hit = (icb_cmd_addr[31:13] == BASE_ADDR[31:13]);
   assign idx_ok     = ({19'b0, idx_full} < (32'd1 << BUF_AW));
   assign hit_ctrl   = region_hit & (off == 13'd0);
   assign hit_mode   = region_hit & (off == 13'd4);
   assign hit_win    = region_hit & (off >= 13'd8) & idx_ok;

   assign do_bufwr = hit_win & ~icb_cmd_read & ~acc_busy;
   assign do_bufrd = hit_win & icb_cmd_read & RDBACK;
   assign do_start = hit_ctrl & ~icb_cmd_read & icb_cmd_wdata[0] & ~acc_busy;
   assign do_w1c   = cmd_fire & hit_ctrl & ~icb_cmd_read & icb_cmd_wdata[1];
   assign cmd_err  = ~(hit_ctrl | hit_mode | hit_win)
                   | (hit_ctrl & ~icb_cmd_read & icb_cmd_wdata[0] & acc_busy)
                   | (hit_win & ~icb_cmd_read & acc_busy)
                   | (hit_win & icb_cmd_read & ~RDBACK);

   always_comb begin
      rd_value = 32'd0;
      if (icb_cmd_read && hit_ctrl)
         rd_value = {29'd0, done_sticky_reg, acc_busy, 1'b0};
      else if (icb_cmd_read && hit_mode)
         rd_value = {30'd0, mode_reg};
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (cmd_fire) state_next = S_ISSUE;
         S_ISSUE:  if (op_re_reg) state_next = S_RDWAIT;
                   else if (rsp_fire) state_next = S_IDLE;
                   else state_next = S_RSP;
         S_RDWAIT: state_next = rsp_fire ? S_IDLE : S_RSP;
         S_RSP:    if (rsp_fire) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         rsp_valid_reg   <= 1'b0;
         rsp_rdata_reg   <= 32'd0;
         rsp_err_reg     <= 1'b0;
         op_we_reg       <= 1'b0;
         op_re_reg       <= 1'b0;
         op_start_reg    <= 1'b0;
         buf_addr_reg    <= '0;
         buf_wdata_reg   <= 32'd0;
         buf_wmask_reg   <= 4'd0;
         mode_reg        <= 2'd0;
         done_sticky_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (cmd_fire) begin
            // Buffer reads raise rsp_valid only once the data is back.
            rsp_valid_reg <= ~do_bufrd;
            rsp_rdata_reg <= rd_value;
            rsp_err_reg   <= cmd_err;
            op_we_reg     <= do_bufwr;
            op_re_reg     <= do_bufrd;
            op_start_reg  <= do_start;
            if (do_bufwr || do_bufrd) begin
               buf_addr_reg  <= idx_full[BUF_AW-1:0];
               buf_wdata_reg <= icb_cmd_wdata;
               buf_wmask_reg <= icb_cmd_wmask;
            end
            if (hit_mode && !icb_cmd_read)
               mode_reg <= icb_cmd_wdata[1:0];
         end else if (state_reg == S_RDWAIT) begin
            rsp_valid_reg <= ~rsp_fire;
            rsp_rdata_reg <= buf_rdata;
         end else if (rsp_fire) begin
            rsp_valid_reg <= 1'b0;
         end
         // A completion in the same cycle as a clear must not be lost.
         if (acc_done)
            done_sticky_reg <= 1'b1;
         else if (do_w1c || start_o)
            done_sticky_reg <= 1'b0;
      end
   end

endmodule
